// File: rtl/kbd_pkg.sv
// Shared constants and types for the keyboard-to-display sequencing controller.
package kbd_pkg;

    localparam int LETTER_W   = 5;
    localparam int NUM_DIGITS = 4;

    localparam int CODE_SPACE = 26;
    localparam int CODE_BLANK = CODE_SPACE;
    localparam int CODE_BKSP  = 27;
    localparam int CODE_CLEAR = 28;

    typedef enum logic [1:0] {
        EV_CHAR  = 2'd0,
        EV_BKSP  = 2'd1,
        EV_CLEAR = 2'd2,
        EV_NONE  = 2'd3
    } ev_kind_t;

    // Map a raw key code onto the action it requests; 29..31 carry no action.
    function automatic ev_kind_t classify_code(input logic [LETTER_W-1:0] code);
        ev_kind_t kind;
        if (int'(code) <= CODE_SPACE) begin
            kind = EV_CHAR;
        end else if (int'(code) == CODE_BKSP) begin
            kind = EV_BKSP;
        end else if (int'(code) == CODE_CLEAR) begin
            kind = EV_CLEAR;
        end else begin
            kind = EV_NONE;
        end
        return kind;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Digit-scan timebase: refresh counter 0..REFRESH_DIV-1 and a 2-bit digit index
// that advances each time the counter wraps.
module scan_timer #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] idx,
    output logic       tick
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             tick_d;

    // Next-state: wrap at the terminal value and step the digit index.
    always_comb begin
        tick_d = (cnt_q == CNT_LAST);
        cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
        idx_d  = tick_d ? idx_q + 2'd1 : idx_q;
    end

    // Counter and index registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx  = idx_q;
    assign tick = tick_d;

endmodule

// File: rtl/kbd_display_ctrl.sv
// Captures key events into a 4-character scrolling buffer and drives the
// multiplexed 7-segment anodes plus the code of the currently lit digit.
module kbd_display_ctrl
    import kbd_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int LETTER_W    = kbd_pkg::LETTER_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LETTER_W-1:0] letter_in,
    input  logic                letter_valid,
    output logic [3:0]          an,
    output logic [LETTER_W-1:0] digit_code,
    output logic [2:0]          count
);

    localparam logic [LETTER_W-1:0] BLANK = LETTER_W'(CODE_BLANK);

    logic [1:0] scan_idx;
    logic       scan_tick_unused;

    scan_timer #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_scan_timer (
        .clk (clk),
        .rst (rst),
        .idx (scan_idx),
        .tick(scan_tick_unused)
    );

    logic                                   valid_prev_q, valid_prev_d;
    logic                                   ev_q, ev_d;
    logic [LETTER_W-1:0]                    ev_code_q, ev_code_d;
    logic [NUM_DIGITS-1:0][LETTER_W-1:0]    disp_buf_q, disp_buf_d;
    logic [2:0]                             count_q, count_d;
    logic [3:0]                             an_q, an_d;
    logic [LETTER_W-1:0]                    digit_code_q, digit_code_d;
    ev_kind_t                               ev_kind;

    // Edge-detect key events, apply the captured event to the buffer one cycle
    // later, and select the anode/code pair from the same digit index.
    always_comb begin
        valid_prev_d = letter_valid;
        ev_d         = letter_valid && !valid_prev_q &&
                       (classify_code(LETTER_W'(letter_in)) != EV_NONE);
        ev_code_d    = letter_in;

        disp_buf_d   = disp_buf_q;
        count_d      = count_q;
        ev_kind      = classify_code(ev_code_q);

        if (ev_q) begin
            unique case (ev_kind)
                EV_CHAR: begin
                    disp_buf_d = {disp_buf_q[NUM_DIGITS-2:0], ev_code_q};
                    count_d    = (count_q >= 3'(NUM_DIGITS)) ? 3'(NUM_DIGITS)
                                                             : count_q + 3'd1;
                end
                EV_BKSP: begin
                    if (count_q != 3'd0) begin
                        disp_buf_d = {BLANK, disp_buf_q[NUM_DIGITS-1:1]};
                        count_d    = count_q - 3'd1;
                    end
                end
                EV_CLEAR: begin
                    disp_buf_d = {NUM_DIGITS{BLANK}};
                    count_d    = 3'd0;
                end
                default: begin
                end
            endcase
        end

        an_d         = ~(4'b0001 << scan_idx);
        digit_code_d = disp_buf_q[scan_idx];
    end

    // All state and outputs registered; reset wins over any pending event.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_prev_q <= 1'b0;
            ev_q         <= 1'b0;
            ev_code_q    <= BLANK;
            disp_buf_q   <= {NUM_DIGITS{BLANK}};
            count_q      <= 3'd0;
            an_q         <= 4'b1111;
            digit_code_q <= BLANK;
        end else begin
            valid_prev_q <= valid_prev_d;
            ev_q         <= ev_d;
            ev_code_q    <= ev_code_d;
            disp_buf_q   <= disp_buf_d;
            count_q      <= count_d;
            an_q         <= an_d;
            digit_code_q <= digit_code_d;
        end
    end

    assign an         = an_q;
    assign digit_code = digit_code_q;
    assign count      = count_q;

endmodule
